iir_filter_driver: RTL and testbench
====================================

# iir_filter_driver

Initiator-side sequencer for the team's `IIRFilter` start/done handshake. It accepts ADC samples on a valid/ready stream and issues exactly one `start` pulse per sample. It waits for `done`, then captures the filtered value into a small result FIFO that downstream logic drains on a second valid/ready stream. It sits between the ADC capture path and the filter, and adds a timeout watchdog so a stalled filter cannot hang the sample path.

## Interface
- `SIGNAL_BITS`, 24: width of samples and results, two's complement.
- `FIFO_DEPTH`, 4: number of result FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 64: maximum number of WAIT cycles before the operation is abandoned; at least 2.
- `clk_i` in 1: single clock; all logic is rising-edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `sample_i` in SIGNAL_BITS: input sample.
- `sample_valid_i` in 1: `sample_i` is valid.
- `sample_ready_o` out 1: the block accepts `sample_i` this cycle.
- `filt_start_o` out 1: one-cycle start pulse to the filter.
- `filt_signal_o` out SIGNAL_BITS: sample presented to the filter.
- `filt_signal_i` in SIGNAL_BITS: filter output.
- `filt_done_i` in 1: filter completion strobe.
- `result_o` out SIGNAL_BITS: head of the result FIFO.
- `result_valid_o` out 1: the FIFO is non-empty.
- `result_ready_i` in 1: downstream pops the FIFO head.
- `busy_o` out 1: the FSM is not in IDLE.
- `timeout_o` out 1: sticky flag, set on any timeout.
- `timeout_count_o` out 8: saturating count of timeouts.

## Operation
- The FSM states are IDLE, START and WAIT (enum in the package).
- `sample_ready_o` = (state == IDLE) && (FIFO count < FIFO_DEPTH). It is combinational and does not depend on `sample_valid_i`.
- **IDLE:** on `sample_valid_i && sample_ready_o`, register `sample_i` into `filt_signal_o` and go to START.
- **START:** assert `filt_start_o` for this single cycle, clear the timeout counter, go to WAIT.
- **WAIT:**
  - If `filt_done_i` is high, push `filt_signal_i` into the FIFO and go to IDLE.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES without `done`: set `timeout_o`, increment `timeout_count_o` (it saturates at 255), push nothing, go to IDLE.
- `filt_done_i` is ignored in IDLE and START. This covers a `done` that coincides with the start pulse and late `done` pulses after a timeout.
- `filt_signal_o` holds its value from START until the next accepted sample; it does not change during WAIT.
- Because a sample is only accepted when the FIFO has space, and only one operation is in flight, a push never overflows.
- **FIFO:** first-word fall-through, so `result_o` is the head entry. A pop occurs on `result_valid_o && result_ready_i`. A simultaneous push and pop leaves the count unchanged. A pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 states wide.
- No arithmetic is done on sample data; it passes through bit-exact.
- **Reset (asynchronous, also mid-operation):** state becomes IDLE, FIFO empty. `filt_start_o`=0, `filt_signal_o`=0, `result_valid_o`=0, `result_o`=0, `busy_o`=0, `timeout_o`=0, `timeout_count_o`=0. Any in-flight sample is discarded. The filter itself is reset by its own owner; stale `done` pulses arriving in IDLE are harmless.

## Timing
- Sample accepted at edge k: `filt_start_o`=1 during cycle k+1 only; `filt_signal_o` is valid from cycle k+1.
- The earliest `done` that is honoured is in cycle k+2.
- `done` sampled at edge m: `result_valid_o`=1 from cycle m+1 if the FIFO was empty; `sample_ready_o` returns in cycle m+1.
- Minimum sample-to-sample period is 3 cycles, plus the filter latency.
- Timeout: with no `done`, `timeout_o` rises TIMEOUT_CYCLES+2 cycles after acceptance and `sample_ready_o` returns in the same cycle.
- `busy_o` is registered and equals (state != IDLE).

## Structure
- Package `iir_pkg`: the `iir_drv_state_t` enum (IDLE, START, WAIT) and the default SIGNAL_BITS constant, shared with future filter-chain blocks.
- One sub-module: `iir_result_fifo` (parameters SIGNAL_BITS, FIFO_DEPTH; ports push, pop, data in/out, count, empty, full, active-low asynchronous reset).
- The FSM, the timeout counter and the sample register live in `iir_filter_driver`.

## Test plan
- **Single sample:** the filter model returns the input negated after 5 cycles; send 0x000123. Expect exactly one `filt_start_o` pulse, `result_o`=0xFFFEDD, `timeout_o`=0.
- **Back-to-back with FIFO full:** `result_ready_i`=0, send 6 samples. Expect 4 results queued and `sample_ready_o`=0 after the 4th. Popping one re-enables acceptance. Results come out in order.
- **Timeout:** the model never asserts `done`. Expect `timeout_o`=1 and `timeout_count_o`=1 at acceptance +66 cycles, and no FIFO push. A late `done` at +70 is ignored and the count is unchanged.
- **Stray done:** `done` asserted in the START cycle and in IDLE is ignored. The real `done` at +5 yields exactly one result.
- **Simultaneous push/pop:** FIFO holding 2 entries, with push and pop in the same cycle. Count stays at 2 and the order is preserved.
- **Reset mid-WAIT:** drive `reset_i` low asynchronously between edges. All outputs go to 0 immediately, the FIFO is empty, and after release the next sample completes normally.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter-chain blocks.
package iir_pkg;

    // Default sample/result width for filter-chain blocks
    localparam int unsigned IIR_SIGNAL_BITS = 24;

    // Driver sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } iir_drv_state_t;

endpackage

// File: rtl/iir_result_fifo.sv
// First-word fall-through result FIFO with occupancy count.
module iir_result_fifo
    import iir_pkg::*;
#(
    parameter int unsigned SIGNAL_BITS = IIR_SIGNAL_BITS,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             push,
    input  logic                             pop,
    input  logic [SIGNAL_BITS-1:0]           wr_data,
    output logic [SIGNAL_BITS-1:0]           rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
    output logic                             empty,
    output logic                             full
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [SIGNAL_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so the output is clean after reset
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/iir_filter_driver.sv
// Start/done sequencer for IIRFilter with result FIFO and timeout watchdog.
module iir_filter_driver
    import iir_pkg::*;
#(
    parameter int unsigned SIGNAL_BITS    = IIR_SIGNAL_BITS,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [SIGNAL_BITS-1:0] sample_i,
    input  logic                   sample_valid_i,
    output logic                   sample_ready_o,
    output logic                   filt_start_o,
    output logic [SIGNAL_BITS-1:0] filt_signal_o,
    input  logic [SIGNAL_BITS-1:0] filt_signal_i,
    input  logic                   filt_done_i,
    output logic [SIGNAL_BITS-1:0] result_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic [7:0]             timeout_count_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    iir_drv_state_t   state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             accept;
    logic             fifo_push;

    assign sample_ready_o = (state == ST_IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept         = sample_valid_i && sample_ready_o;
    assign fifo_push      = (state == ST_WAIT) && filt_done_i && !fifo_full;
    assign result_valid_o = !fifo_empty;

    // Sequencer: accept sample, pulse start, wait for done or give up on timeout
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state           <= ST_IDLE;
            filt_start_o    <= 1'b0;
            filt_signal_o   <= '0;
            busy_o          <= 1'b0;
            timeout_o       <= 1'b0;
            timeout_count_o <= '0;
            tmo_cnt         <= '0;
        end else begin
            filt_start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        filt_signal_o <= sample_i;
                        filt_start_o  <= 1'b1;
                        busy_o        <= 1'b1;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (filt_done_i) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Last allowed WAIT cycle without done
                        timeout_o <= 1'b1;
                        if (timeout_count_o != 8'hFF)
                            timeout_count_o <= timeout_count_o + 8'd1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    iir_result_fifo #(
        .SIGNAL_BITS (SIGNAL_BITS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (fifo_push),
        .pop     (result_ready_i),
        .wr_data (filt_signal_i),
        .rd_data (result_o),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_iir_filter_driver.sv
// Self-checking bench for iir_filter_driver with a queue-based reference model.
module tb_iir_filter_driver;

    localparam int unsigned SB  = 24;
    localparam int unsigned DEP = 4;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [SB-1:0] sample_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic          filt_start_o;
    logic [SB-1:0] filt_signal_o;
    logic [SB-1:0] filt_signal_i;
    logic          filt_done_i;
    logic [SB-1:0] result_o;
    logic          result_valid_o;
    logic          result_ready_i;
    logic          busy_o;
    logic          timeout_o;
    logic [7:0]    timeout_count_o;

    int            tests = 0;
    int            fails = 0;
    int            start_pulses = 0;

    // Reference model: expected FIFO contents and timeout bookkeeping
    logic [SB-1:0] exp_q[$];
    int unsigned   m_tcnt = 0;
    bit            m_tflag = 1'b0;

    iir_filter_driver #(
        .SIGNAL_BITS    (SB),
        .FIFO_DEPTH     (DEP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .sample_i        (sample_i),
        .sample_valid_i  (sample_valid_i),
        .sample_ready_o  (sample_ready_o),
        .filt_start_o    (filt_start_o),
        .filt_signal_o   (filt_signal_o),
        .filt_signal_i   (filt_signal_i),
        .filt_done_i     (filt_done_i),
        .result_o        (result_o),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o),
        .timeout_count_o (timeout_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (filt_start_o === 1'b1) start_pulses++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, "_valid"}, 32'(result_valid_o), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk({tag, "_head"}, 32'(result_o), 32'(exp_q[0]));
    endtask

    task automatic pop_one(input string tag);
        chk_fifo(tag);
        if (exp_q.size() > 0) begin
            result_ready_i = 1'b1;
            cycle();
            result_ready_i = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    // One complete operation: accept d, then either done after lat WAIT cycles or a timeout
    task automatic run_op(input logic [SB-1:0] d, input int unsigned lat, input bit do_done,
                          input bit stray, input bit pop_at_done);
        logic [SB-1:0] r;
        int            n;
        bit            got;
        r   = -d;
        got = 1'b0;
        sample_i       = d;
        sample_valid_i = 1'b1;
        for (n = 0; n < 200; n++) begin
            if (sample_ready_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            cycle();
        end
        if (!got) begin
            chk("accept_wait", 32'(sample_ready_o), 32'(1));
            sample_valid_i = 1'b0;
            return;
        end
        cycle();
        sample_valid_i = 1'b0;
        sample_i       = SB'($urandom);
        if (stray) begin
            filt_done_i   = 1'b1;
            filt_signal_i = SB'($urandom);
        end
        chk("start_hi", 32'(filt_start_o), 32'(1));
        chk("sig_out", 32'(filt_signal_o), 32'(d));
        chk("busy_start", 32'(busy_o), 32'(1));
        chk("ready_busy", 32'(sample_ready_o), 32'(0));
        cycle();
        filt_done_i = 1'b0;
        chk("start_lo", 32'(filt_start_o), 32'(0));
        chk("sig_hold", 32'(filt_signal_o), 32'(d));
        if (do_done) begin
            repeat (lat) cycle();
            chk("busy_wait", 32'(busy_o), 32'(1));
            filt_done_i   = 1'b1;
            filt_signal_i = r;
            if (pop_at_done) begin
                chk_fifo("pre_pop");
                result_ready_i = 1'b1;
            end
            cycle();
            filt_done_i    = 1'b0;
            filt_signal_i  = SB'($urandom);
            result_ready_i = 1'b0;
            if (pop_at_done) void'(exp_q.pop_front());
            exp_q.push_back(r);
            chk("busy_done", 32'(busy_o), 32'(0));
            chk("ready_done", 32'(sample_ready_o), 32'(exp_q.size() < DEP));
            chk("tflag_keep", 32'(timeout_o), 32'(m_tflag));
            chk_fifo("after_done");
        end else begin
            repeat (TMO - 1) cycle();
            chk("tmo_early_busy", 32'(busy_o), 32'(1));
            chk("tmo_early_flag", 32'(timeout_o), 32'(m_tflag));
            cycle();
            m_tflag = 1'b1;
            if (m_tcnt < 255) m_tcnt++;
            chk("tmo_flag", 32'(timeout_o), 32'(1));
            chk("tmo_count", 32'(timeout_count_o), 32'(m_tcnt));
            chk("tmo_busy", 32'(busy_o), 32'(0));
            chk("tmo_ready", 32'(sample_ready_o), 32'(exp_q.size() < DEP));
            chk_fifo("tmo_nopush");
        end
    endtask

    initial begin
        logic [SB-1:0] d;
        int            sp;
        reset_i        = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        filt_signal_i  = '0;
        filt_done_i    = 1'b0;
        result_ready_i = 1'b0;
        cycle();
        cycle();

        // Reset state
        chk("rst_start", 32'(filt_start_o), 32'(0));
        chk("rst_sig", 32'(filt_signal_o), 32'(0));
        chk("rst_valid", 32'(result_valid_o), 32'(0));
        chk("rst_result", 32'(result_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_tflag", 32'(timeout_o), 32'(0));
        chk("rst_tcnt", 32'(timeout_count_o), 32'(0));
        chk("rst_ready", 32'(sample_ready_o), 32'(1));
        reset_i = 1'b1;
        cycle();

        // Single sample, filter answers with the negated value
        sp = start_pulses;
        run_op(24'h000123, 3, 1'b1, 1'b0, 1'b0);
        chk("single_pulses", 32'(start_pulses - sp), 32'(1));
        chk("single_result", 32'(result_o), 32'(24'hFFFEDD));
        chk("single_tflag", 32'(timeout_o), 32'(0));
        pop_one("single_pop");
        chk_fifo("single_empty");

        // Back-to-back with downstream stalled until the FIFO fills
        for (int i = 0; i < 4; i++)
            run_op(SB'($urandom), $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
        chk("full_ready", 32'(sample_ready_o), 32'(0));
        sp = start_pulses;
        sample_i       = SB'($urandom);
        sample_valid_i = 1'b1;
        repeat (3) cycle();
        chk("full_blocked_ready", 32'(sample_ready_o), 32'(0));
        chk("full_no_start", 32'(start_pulses - sp), 32'(0));
        sample_valid_i = 1'b0;
        pop_one("full_pop1");
        chk("full_reopen", 32'(sample_ready_o), 32'(1));
        run_op(SB'($urandom), $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
        chk("full_ready2", 32'(sample_ready_o), 32'(0));
        pop_one("full_pop2");
        run_op(SB'($urandom), $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pop_one("full_drain");
        chk_fifo("full_empty");

        // Stray done pulses in IDLE and in the START cycle
        filt_done_i   = 1'b1;
        filt_signal_i = SB'($urandom);
        cycle();
        cycle();
        filt_done_i = 1'b0;
        chk_fifo("stray_idle");
        chk("stray_idle_busy", 32'(busy_o), 32'(0));
        sp = start_pulses;
        d  = SB'($urandom);
        run_op(d, 3, 1'b1, 1'b1, 1'b0);
        chk("stray_count", 32'(exp_q.size()), 32'(1));
        chk("stray_pulses", 32'(start_pulses - sp), 32'(1));
        pop_one("stray_pop");
        chk_fifo("stray_empty");

        // Simultaneous push and pop with two entries queued
        run_op(SB'($urandom), $urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
        run_op(SB'($urandom), $urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
        run_op(SB'($urandom), $urandom_range(0, 4), 1'b1, 1'b0, 1'b1);
        pop_one("pp_pop1");
        pop_one("pp_pop2");
        chk_fifo("pp_empty");

        // Timeout, then a late done in IDLE is ignored
        run_op(SB'($urandom), 0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        filt_done_i   = 1'b1;
        filt_signal_i = SB'($urandom);
        cycle();
        filt_done_i = 1'b0;
        chk_fifo("late_done");
        chk("late_tcnt", 32'(timeout_count_o), 32'(m_tcnt));
        chk("late_busy", 32'(busy_o), 32'(0));

        // Normal operation still works after a timeout
        run_op(SB'($urandom), $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
        pop_one("post_tmo_pop");

        // Drive the timeout counter to saturation
        while (m_tcnt < 255) run_op(SB'($urandom), 0, 1'b0, 1'b0, 1'b0);
        run_op(SB'($urandom), 0, 1'b0, 1'b0, 1'b0);
        chk("sat_tcnt", 32'(timeout_count_o), 32'(255));

        // Reset in the middle of WAIT with a queued result
        run_op(SB'($urandom), $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
        sample_i       = SB'($urandom);
        sample_valid_i = 1'b1;
        cycle();
        sample_valid_i = 1'b0;
        cycle();
        cycle();
        #3;
        reset_i = 1'b0;
        #1;
        exp_q.delete();
        m_tflag = 1'b0;
        m_tcnt  = 0;
        chk("mrst_start", 32'(filt_start_o), 32'(0));
        chk("mrst_sig", 32'(filt_signal_o), 32'(0));
        chk("mrst_valid", 32'(result_valid_o), 32'(0));
        chk("mrst_result", 32'(result_o), 32'(0));
        chk("mrst_busy", 32'(busy_o), 32'(0));
        chk("mrst_tflag", 32'(timeout_o), 32'(0));
        chk("mrst_tcnt", 32'(timeout_count_o), 32'(0));
        cycle();
        #2;
        reset_i = 1'b1;
        cycle();
        chk_fifo("mrst_after");
        d = SB'($urandom);
        run_op(d, $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
        chk("mrst_result_ok", 32'(result_o), 32'(SB'(-d)));
        pop_one("mrst_pop");
        chk_fifo("mrst_empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
